// File: rtl/usb_xfer_engine.sv
// Command-driven transfer engine: moves words between host streams and a
// region-mapped memory port, then reports a one-beat status word.
module usb_xfer_engine #(
    parameter int unsigned NUM_REGIONS = 8,
    parameter int unsigned ADDR_W      = 26,
    parameter int unsigned DATA_W      = 32,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = {
        ADDR_W'(32'h000_0000), ADDR_W'(32'h1E0_0000), ADDR_W'(32'h1F0_0000), ADDR_W'(32'h000_0000),
        ADDR_W'(32'h200_0000), ADDR_W'(32'h100_0000), ADDR_W'(32'h000_0000), ADDR_W'(32'h000_0000)},
    parameter logic [NUM_REGIONS*24-1:0] REGION_WORDS = {
        24'h00_0000, 24'h00_0004, 24'h00_0004, 24'h00_0000,
        24'h00_0008, 24'h00_8000, 24'h40_0000, 24'h00_0000},
    parameter logic [NUM_REGIONS-1:0] REGION_DIR = NUM_REGIONS'(8'b0000_1000)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] ctrl_tdata,
    input  logic              ctrl_tvalid,
    output logic              ctrl_tready,
    input  logic [DATA_W-1:0] tx_tdata,
    input  logic              tx_tvalid,
    input  logic              tx_tlast,
    output logic              tx_tready,
    output logic [DATA_W-1:0] rx_tdata,
    output logic              rx_tvalid,
    output logic              rx_tlast,
    input  logic              rx_tready,
    output logic [DATA_W-1:0] resp_tdata,
    output logic              resp_tvalid,
    output logic              resp_tlast,
    input  logic              resp_tready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic              mem_wr_ready,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              mem_rd_valid,
    output logic              busy
);

    localparam int unsigned BPW   = DATA_W / 8;
    localparam int unsigned CNT_W = 24;

    localparam logic [7:0] CODE_OK     = 8'hA5;
    localparam logic [7:0] CODE_NO_REG = 8'hE0;
    localparam logic [7:0] CODE_TOOBIG = 8'hE1;
    localparam logic [7:0] CODE_SHORT  = 8'hE2;

    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

    state_t             state, state_next;
    logic [7:0]         id;
    logic [CNT_W-1:0]   eff_len;
    logic [CNT_W-1:0]   count;
    logic [ADDR_W-1:0]  offset;
    logic [7:0]         code, code_next;
    logic               wr_hs, rd_hs, cmd_hs, last_beat;

    // Region lookups return 0 / unmapped for IDs beyond the table.
    function automatic logic [CNT_W-1:0] words_of(input logic [7:0] rid);
        logic [CNT_W-1:0] w;
        w = '0;
        for (int i = 0; i < NUM_REGIONS; i++)
            if (rid == 8'(i)) w = REGION_WORDS[i*CNT_W +: CNT_W];
        return w;
    endfunction

    function automatic logic [ADDR_W-1:0] base_of(input logic [7:0] rid);
        logic [ADDR_W-1:0] b;
        b = '0;
        for (int i = 0; i < NUM_REGIONS; i++)
            if (rid == 8'(i)) b = REGION_BASE[i*ADDR_W +: ADDR_W];
        return b;
    endfunction

    function automatic logic dir_of(input logic [7:0] rid);
        logic d;
        d = 1'b0;
        for (int i = 0; i < NUM_REGIONS; i++)
            if (rid == 8'(i)) d = REGION_DIR[i];
        return d;
    endfunction

    logic [7:0]       cmd_id;
    logic [CNT_W-1:0] cmd_len;
    logic [CNT_W-1:0] cmd_words;

    assign cmd_id    = ctrl_tdata[7:0];
    assign cmd_len   = ctrl_tdata[31:8];
    assign cmd_words = words_of(cmd_id);
    assign cmd_hs    = ctrl_tvalid & (state == IDLE);
    assign last_beat = (count == eff_len - 24'd1);
    assign mem_addr  = base_of(id) + offset;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next  = state;
        code_next   = code;
        ctrl_tready = 1'b0;
        tx_tready   = 1'b0;
        mem_wr      = 1'b0;
        mem_wr_data = '0;
        rx_tvalid   = 1'b0;
        rx_tdata    = '0;
        rx_tlast    = 1'b0;
        mem_rd      = 1'b0;
        resp_tvalid = 1'b0;
        resp_tlast  = 1'b0;
        resp_tdata  = '0;
        wr_hs       = 1'b0;
        rd_hs       = 1'b0;
        case (state)
            IDLE: begin
                ctrl_tready = 1'b1;
                if (ctrl_tvalid) begin
                    // Out-of-table IDs look up as zero words, so one test covers both rejects.
                    if (cmd_words == '0) begin
                        code_next  = CODE_NO_REG;
                        state_next = RESP;
                    end else if (cmd_len > cmd_words) begin
                        code_next  = CODE_TOOBIG;
                        state_next = RESP;
                    end else begin
                        state_next = dir_of(cmd_id) ? READ : WRITE;
                    end
                end
            end
            WRITE: begin
                tx_tready   = mem_wr_ready;
                wr_hs       = tx_tvalid & mem_wr_ready;
                mem_wr      = wr_hs;
                mem_wr_data = wr_hs ? tx_tdata : '0;
                if (wr_hs) begin
                    if (last_beat) begin
                        code_next  = CODE_OK;
                        state_next = RESP;
                    end else if (tx_tlast) begin
                        code_next  = CODE_SHORT;
                        state_next = RESP;
                    end
                end
            end
            READ: begin
                rx_tvalid = mem_rd_valid;
                rx_tdata  = mem_rd_valid ? mem_rd_data : '0;
                rx_tlast  = mem_rd_valid & last_beat;
                rd_hs     = mem_rd_valid & rx_tready;
                mem_rd    = rd_hs;
                if (rd_hs && last_beat) begin
                    code_next  = CODE_OK;
                    state_next = RESP;
                end
            end
            RESP: begin
                resp_tvalid = 1'b1;
                resp_tlast  = 1'b1;
                resp_tdata  = DATA_W'({code, id, count[15:0]});
                if (resp_tready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Transfer bookkeeping: latched on command, advanced per accepted word.
    always_ff @(posedge clk) begin
        if (rst) begin
            id      <= '0;
            eff_len <= '0;
            count   <= '0;
            offset  <= '0;
            code    <= '0;
        end else begin
            code <= code_next;
            if (cmd_hs) begin
                id      <= cmd_id;
                eff_len <= (cmd_len == '0) ? cmd_words : cmd_len;
                count   <= '0;
                offset  <= '0;
            end else if (wr_hs || rd_hs) begin
                count  <= count + 24'd1;
                offset <= offset + ADDR_W'(BPW);
            end else if (state == RESP && resp_tready) begin
                offset <= '0;
            end
        end
    end

endmodule

// File: tb/tb_usb_xfer_engine.sv
// Self-checking bench for usb_xfer_engine: spec vector table, hand-built
// reset/stall sequences, and randomized commands against a transfer-level model.
module tb_usb_xfer_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ctrl_tdata;
    logic        ctrl_tvalid, ctrl_tready;
    logic [31:0] tx_tdata;
    logic        tx_tvalid, tx_tlast, tx_tready;
    logic [31:0] rx_tdata;
    logic        rx_tvalid, rx_tlast, rx_tready;
    logic [31:0] resp_tdata;
    logic        resp_tvalid, resp_tlast, resp_tready;
    logic [25:0] mem_addr;
    logic        mem_wr, mem_wr_ready, mem_rd, mem_rd_valid;
    logic [31:0] mem_wr_data, mem_rd_data;
    logic        busy;

    usb_xfer_engine dut (
        .clk(clk), .rst(rst),
        .ctrl_tdata(ctrl_tdata), .ctrl_tvalid(ctrl_tvalid), .ctrl_tready(ctrl_tready),
        .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid), .tx_tlast(tx_tlast), .tx_tready(tx_tready),
        .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid), .rx_tlast(rx_tlast), .rx_tready(rx_tready),
        .resp_tdata(resp_tdata), .resp_tvalid(resp_tvalid), .resp_tlast(resp_tlast),
        .resp_tready(resp_tready),
        .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wr_data(mem_wr_data),
        .mem_wr_ready(mem_wr_ready), .mem_rd(mem_rd), .mem_rd_data(mem_rd_data),
        .mem_rd_valid(mem_rd_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Region map as the host sees it.
    int unsigned m_base  [8] = '{32'h0, 32'h0, 32'h100_0000, 32'h200_0000, 32'h0, 32'h1F0_0000, 32'h1E0_0000, 32'h0};
    int unsigned m_words [8] = '{0, 32'h40_0000, 32'h8000, 8, 0, 4, 4, 0};

    logic [31:0] wr_addr_q[$], wr_data_q[$], rx_addr_q[$], rx_data_q[$];
    bit          rx_last_q[$];
    int          rd_pulses;

    typedef struct {
        logic [31:0] cmd;
        int          tlast_at;
        int          mode;
        logic [31:0] exp_resp;
        logic [31:0] exp_addr0;
        int          exp_n;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rd_pat(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'h5A5A_0000;
    endfunction

    task automatic park();
        ctrl_tvalid = 1'b0; ctrl_tdata = '0;
        tx_tvalid = 1'b0; tx_tdata = '0; tx_tlast = 1'b0;
        rx_tready = 1'b0; resp_tready = 1'b0;
        mem_wr_ready = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = '0;
    endtask

    task automatic send_cmd(input logic [31:0] cmd);
        @(negedge clk);
        park();
        ctrl_tdata = cmd; ctrl_tvalid = 1'b1;
        #1;
        for (int w = 0; w < 20 && !ctrl_tready; w++) begin
            @(negedge clk); #1;
        end
        check("cmd_accept", 32'(ctrl_tready), 32'd1);
        @(posedge clk);
    endtask

    // Runs one command to completion and checks it against the transfer model.
    task automatic run_xfer(input logic [31:0] cmd, input int tlast_at, input int mode,
                            output logic [31:0] got_resp, output int got_n,
                            output logic [31:0] got_addr0);
        int          id, len, words, eff, n, n_tx, tx_idx, exp_wr, exp_rx;
        bit          rd, done;
        logic [7:0]  code;
        logic [31:0] base, exp_resp, ea;
        logic [31:0] txw[16];
        id    = int'(cmd[7:0]);
        len   = int'(cmd[31:8]);
        words = (id < 8) ? int'(m_words[id]) : 0;
        base  = (id < 8) ? m_base[id] : 32'h0;
        rd    = (id == 3);
        eff   = (len == 0) ? words : len;
        n     = 0;
        if (words == 0)                           code = 8'hE0;
        else if (len > words)                     code = 8'hE1;
        else if (rd)                              begin n = eff; code = 8'hA5; end
        else if (tlast_at > 0 && tlast_at < eff)  begin n = tlast_at; code = 8'hE2; end
        else                                      begin n = eff; code = 8'hA5; end
        exp_wr   = (n > 0 && !rd) ? n : 0;
        exp_rx   = (n > 0 && rd) ? n : 0;
        n_tx     = (exp_wr > 0) ? exp_wr : 2;
        exp_resp = {code, 8'(id), 16'(n)};
        for (int i = 0; i < 16; i++) txw[i] = $urandom;
        wr_addr_q.delete(); wr_data_q.delete();
        rx_addr_q.delete(); rx_data_q.delete(); rx_last_q.delete();
        rd_pulses = 0;
        got_resp  = '0;

        send_cmd(cmd);
        tx_idx = 0;
        done   = 0;
        for (int cyc = 0; cyc < 600 && !done; cyc++) begin
            @(negedge clk);
            ctrl_tvalid = 1'b0;
            if (mode == 0) begin
                tx_tvalid = 1'b1; mem_wr_ready = 1'b1; rx_tready = 1'b1;
                mem_rd_valid = 1'b1; resp_tready = 1'b1;
            end else if (mode == 1) begin
                tx_tvalid = 1'b1; mem_wr_ready = 1'b1; rx_tready = cyc[0];
                mem_rd_valid = 1'b1; resp_tready = 1'b1;
            end else begin
                tx_tvalid    = ($urandom_range(0, 3) != 0);
                mem_wr_ready = ($urandom_range(0, 3) != 0);
                rx_tready    = ($urandom_range(0, 3) != 0);
                mem_rd_valid = ($urandom_range(0, 3) != 0);
                resp_tready  = ($urandom_range(0, 2) != 0);
            end
            tx_tvalid   = tx_tvalid && (tx_idx < n_tx);
            tx_tdata    = (tx_idx < 16) ? txw[tx_idx] : 32'h0;
            tx_tlast    = (tx_idx + 1 == tlast_at);
            mem_rd_data = rd_pat(32'(mem_addr));
            #1;
            if (mem_wr) begin
                wr_addr_q.push_back(32'(mem_addr));
                wr_data_q.push_back(mem_wr_data);
                tx_idx++;
            end
            if (rx_tvalid && rx_tready) begin
                rx_addr_q.push_back(32'(mem_addr));
                rx_data_q.push_back(rx_tdata);
                rx_last_q.push_back(rx_tlast);
            end
            if (mem_rd) rd_pulses++;
            if (resp_tvalid && resp_tready) begin
                got_resp = resp_tdata;
                check("resp_tlast", 32'(resp_tlast), 32'd1);
                done = 1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        park();
        #1;
        check("resp_timeout", 32'(done), 32'd1);
        check("resp_model", got_resp, exp_resp);
        check("idle_after", 32'({busy, ctrl_tready}), 32'b01);
        check("wr_count", 32'(wr_addr_q.size()), 32'(exp_wr));
        check("rx_count", 32'(rx_addr_q.size()), 32'(exp_rx));
        check("rd_pulses", 32'(rd_pulses), 32'(exp_rx));
        for (int k = 0; k < wr_addr_q.size() && k < exp_wr; k++) begin
            ea = (base + 32'(4 * k)) & 32'h03FF_FFFF;
            check($sformatf("wr_addr[%0d]", k), wr_addr_q[k], ea);
            check($sformatf("wr_data[%0d]", k), wr_data_q[k], txw[k]);
        end
        for (int k = 0; k < rx_addr_q.size() && k < exp_rx; k++) begin
            ea = (base + 32'(4 * k)) & 32'h03FF_FFFF;
            check($sformatf("rx_addr[%0d]", k), rx_addr_q[k], ea);
            check($sformatf("rx_data[%0d]", k), rx_data_q[k], rd_pat(ea));
            check($sformatf("rx_tlast[%0d]", k), 32'(rx_last_q[k]), 32'(k == exp_rx - 1));
        end
        got_n     = wr_addr_q.size() + rx_addr_q.size();
        got_addr0 = (wr_addr_q.size() > 0) ? wr_addr_q[0] :
                    (rx_addr_q.size() > 0) ? rx_addr_q[0] : 32'hFFFF_FFFF;
    endtask

    initial begin
        logic [31:0] r_resp, r_addr0, cmd;
        int          r_n, id, len, tl;

        vecs[0] = '{32'h0000_0401, 4, 0, 32'hA501_0004, 32'h000_0000, 4};
        vecs[1] = '{32'h0000_0003, 0, 1, 32'hA503_0008, 32'h200_0000, 8};
        vecs[2] = '{32'h0000_0009, 0, 0, 32'hE009_0000, 32'h0, 0};
        vecs[3] = '{32'h0000_0905, 0, 0, 32'hE105_0000, 32'h0, 0};
        vecs[4] = '{32'h0000_0A02, 3, 0, 32'hE202_0003, 32'h100_0000, 3};
        vecs[5] = '{32'h0000_0006, 0, 2, 32'hA506_0004, 32'h1E0_0000, 4};
        vecs[6] = '{32'h0000_0004, 0, 0, 32'hE004_0000, 32'h0, 0};
        vecs[7] = '{32'h0000_0105, 1, 2, 32'hA505_0001, 32'h1F0_0000, 1};
        vecs[8] = '{32'h0000_0500, 0, 0, 32'hE000_0000, 32'h0, 0};

        park();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("rst_ctrl_tready", 32'(ctrl_tready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valids", 32'({tx_tready, rx_tvalid, rx_tlast, resp_tvalid, resp_tlast, mem_wr, mem_rd}), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_data", resp_tdata | rx_tdata | mem_wr_data, 32'd0);
        rst = 1'b0;

        for (int v = 0; v < 9; v++) begin
            run_xfer(vecs[v].cmd, vecs[v].tlast_at, vecs[v].mode, r_resp, r_n, r_addr0);
            check($sformatf("vec%0d_resp", v), r_resp, vecs[v].exp_resp);
            check($sformatf("vec%0d_words", v), 32'(r_n), 32'(vecs[v].exp_n));
            if (vecs[v].exp_n > 0)
                check($sformatf("vec%0d_addr0", v), r_addr0, vecs[v].exp_addr0);
        end

        // Reset after two of four words: abandon without a response.
        send_cmd(32'h0000_0401);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            ctrl_tvalid = 1'b0; tx_tvalid = 1'b1; tx_tdata = 32'h1000 + 32'(k); mem_wr_ready = 1'b1;
            #1;
            check("rstmid_wr", 32'(mem_wr), 32'd1);
            check("rstmid_addr", 32'(mem_addr), 32'(4 * k));
        end
        @(negedge clk);
        rst = 1'b1; tx_tvalid = 1'b0; mem_wr_ready = 1'b0; resp_tready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstmid_ctrl_tready", 32'(ctrl_tready), 32'd1);
        check("rstmid_busy", 32'(busy), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            check("rstmid_no_resp", 32'(resp_tvalid), 32'd0);
        end
        park();
        run_xfer(32'h0000_0401, 4, 0, r_resp, r_n, r_addr0);
        check("rstmid_next_resp", r_resp, 32'hA501_0004);

        // Memory back-pressure mid-write: nothing advances.
        send_cmd(32'h0000_0401);
        @(negedge clk);
        ctrl_tvalid = 1'b0; tx_tvalid = 1'b1; tx_tdata = 32'hAAAA_0000; mem_wr_ready = 1'b1;
        #1;
        check("stall_w0", 32'({mem_wr, 6'(mem_addr)}), 32'b1_000000);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            mem_wr_ready = 1'b0; tx_tdata = 32'hAAAA_0001;
            #1;
            check("stall_tx_tready", 32'(tx_tready), 32'd0);
            check("stall_mem_wr", 32'(mem_wr), 32'd0);
            check("stall_addr", 32'(mem_addr), 32'd4);
        end
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            mem_wr_ready = 1'b1; tx_tdata = 32'hAAAA_0000 + 32'(k);
            #1;
            check("stall_resume_addr", 32'(mem_addr), 32'(4 * k));
            check("stall_resume_data", mem_wr_data, 32'hAAAA_0000 + 32'(k));
        end
        @(negedge clk);
        tx_tvalid = 1'b0; resp_tready = 1'b1;
        #1;
        check("stall_resp", resp_tvalid ? resp_tdata : 32'h0, 32'hA501_0004);
        @(posedge clk);
        @(negedge clk);
        park();
        #1;
        check("stall_idle", 32'(busy), 32'd0);

        // Randomized commands.
        for (int it = 0; it < 40; it++) begin
            id  = $urandom_range(0, 9);
            len = $urandom_range(1, 10);
            if ($urandom_range(0, 4) == 0 && id < 8 && m_words[id] <= 8) len = 0;
            tl  = $urandom_range(0, 11);
            cmd = {8'h0, 16'(len), 8'(id)};
            run_xfer(cmd, tl, 2, r_resp, r_n, r_addr0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/usb_xfer_engine.md
USB_XFER_ENGINE -- requirements
Module: usb_xfer_engine

Interface
REQ-001 SHALL have parameter NUM_REGIONS, default 8, meaning the number of region-table entries; the region ID is cmd[7:0].
REQ-002 SHALL have parameter ADDR_W, default 26, meaning the memory byte-address width.
REQ-003 SHALL have parameter DATA_W, default 32, meaning the stream and memory word width; BPW = DATA_W/8 bytes per word.
REQ-004 SHALL have parameter REGION_BASE [NUM_REGIONS*ADDR_W], default {id1 0x0000000, id2 0x1000000, id3 0x2000000, id5 0x1F00000, id6 0x1E00000, others 0}, meaning each region's base byte address.
REQ-005 SHALL have parameter REGION_WORDS [NUM_REGIONS*24], default {id1 0x400000, id2 0x8000, id3 8, id5 4, id6 4, others 0}, meaning each region's size in words; 0 means the region is unmapped.
REQ-006 SHALL have parameter REGION_DIR [NUM_REGIONS], default id3=1 and others 0, meaning 1 = memory->host (read) and 0 = host->memory (write).
REQ-007 clk  in  1  clock.
REQ-008 rst  in  1  reset, synchronous, active-high.
REQ-009 ctrl_tdata/ctrl_tvalid/ctrl_tready  in/in/out  DATA_W/1/1  command stream; cmd[7:0] = region ID, cmd[31:8] = length in words, where 0 means the full region.
REQ-010 tx_tdata/tx_tvalid/tx_tlast/tx_tready  in/in/in/out  DATA_W/1/1/1  host->FPGA data stream.
REQ-011 rx_tdata/rx_tvalid/rx_tlast/rx_tready  out/out/out/in  DATA_W/1/1/1  FPGA->host data stream.
REQ-012 resp_tdata/resp_tvalid/resp_tlast/resp_tready  out/out/out/in  DATA_W/1/1/1  status stream.
REQ-013 mem_addr  out  ADDR_W  current byte address.
REQ-014 mem_wr/mem_wr_data/mem_wr_ready  out/out/in  1/DATA_W/1  memory write port; a write occurs in any cycle with mem_wr=1.
REQ-015 mem_rd/mem_rd_data/mem_rd_valid  out/in/in  1/DATA_W/1  memory read port; mem_rd_data is valid for mem_addr while mem_rd_valid=1, and mem_rd consumes that word.
REQ-016 busy  out  1  high whenever the state is not IDLE.

Function
REQ-017 SHALL implement the states IDLE, WRITE, READ and RESP.
REQ-018 In IDLE, ctrl_tready SHALL be 1; in all other states it SHALL be 0.
REQ-019 On a command handshake, the block SHALL latch id and len, set eff_len = (len==0 ? REGION_WORDS[id] : len), and clear offset and count.
REQ-020 A command SHALL be rejected, going directly to RESP with code 0xE0, when id >= NUM_REGIONS or REGION_WORDS[id]==0.
REQ-021 A command SHALL be rejected, going directly to RESP with code 0xE1, when len > REGION_WORDS[id].
REQ-022 A valid command SHALL go to READ if REGION_DIR[id]=1, otherwise to WRITE.
REQ-023 mem_addr SHALL equal REGION_BASE[id] + offset, computed modulo 2^ADDR_W, with offset a registered value advancing by BPW per accepted word.
REQ-024 In WRITE, tx_tready SHALL equal mem_wr_ready, mem_wr SHALL equal tx_tvalid & tx_tready, and mem_wr_data SHALL equal tx_tdata when mem_wr=1, else 0.
REQ-025 In WRITE, after the handshake of word number eff_len, the block SHALL enter RESP with code 0xA5.
REQ-026 In WRITE, tx_tlast=1 on a handshake before word eff_len SHALL write that word and then enter RESP with code 0xE2 (short transfer).
REQ-027 In WRITE, tx_tlast=1 on the final word SHALL give code 0xA5, and a missing tlast on the final word SHALL be ignored.
REQ-028 In READ, rx_tvalid SHALL equal mem_rd_valid, rx_tdata SHALL equal mem_rd_data when rx_tvalid=1, else 0, and mem_rd SHALL equal rx_tvalid & rx_tready.
REQ-029 In READ, rx_tlast SHALL be 1 exactly when rx_tvalid=1 and count == eff_len-1.
REQ-030 In READ, after the last handshake the block SHALL enter RESP with code 0xA5.
REQ-031 Outside their respective states, tx_tready, rx_tvalid, mem_wr and mem_rd SHALL be 0.
REQ-032 In RESP, resp_tvalid and resp_tlast SHALL be 1 and resp_tdata SHALL be {code[7:0], id[7:0], count[15:0]}, with zero-extension if DATA_W > 32.
REQ-033 In RESP, on resp_tready the block SHALL return to IDLE, with offset cleared.
REQ-034 The counter count SHALL be 24 bits, hold the number of words moved, and never wrap, because eff_len <= 2^24-1.
REQ-035 Stream stalls SHALL hold all state: tvalid may drop and tready may drop at any cycle with no word loss or duplication.
REQ-036 Data beats arriving while the state is not WRITE SHALL be left unaccepted and are not dropped.

Reset
REQ-037 On rst, the state SHALL be IDLE; offset, count, id and eff_len SHALL be 0; all valid, ready, mem_wr, mem_rd and busy outputs SHALL be 0 except ctrl_tready=1; data outputs SHALL be 0.
REQ-038 When rst is asserted mid-transfer, the transfer SHALL be abandoned without emitting a response, and operation SHALL resume on the first command after rst deasserts.

Verification
REQ-039 cmd 0x00000401 (id1, len 4), 4 tx words with mem_wr_ready=1 -> writes to addresses 0x0, 0x4, 0x8 and 0xC, then resp 0xA5010004.
REQ-040 cmd 0x00000003 (id3, full 8 words) with rx_tready toggling every cycle -> 8 rx words from 0x2000000..0x200001C, tlast only on the 8th, then resp 0xA5030008.
REQ-041 cmd 0x00000009 (id 9 >= NUM_REGIONS) -> resp 0xE0090000, no mem activity; cmd 0x00000905 (len 9 > 4) -> resp 0xE1050000.
REQ-042 cmd 0x00000A02 with tx_tlast on the 3rd word -> 3 writes at 0x1000000..0x1000008, then resp 0xE2020003.
REQ-043 rst asserted after 2 of 4 words are written -> no resp, ctrl_tready=1 next cycle, and the next cmd completes normally.
REQ-044 mem_wr_ready held 0 for 5 cycles mid-WRITE -> tx_tready=0, offset held, no write.
